reg_lock_ctrl: RTL and testbench

Lock controller upstream of the protected 16-bit data register. Decodes a 3-address bus-write interface and forwards data writes downstream as `write`/`data_in`. Drives the register's `not_lock_status` and `lock_override` inputs from a lock state machine. Unlock requires a two-word key sequence within a timeout window, and repeated failures latch a lockout that only reset clears.

---
 rtl/reg_lock_ctrl.sv | 84 ++++++++
 tb/tb_reg_lock_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/reg_lock_ctrl.sv
// reg_lock_ctrl: bus-write decoder and key-sequence lock FSM driving a protected register's lock inputs.
module reg_lock_ctrl #(
  parameter logic [15:0] KEY0     = 16'hA5A5,
  parameter logic [15:0] KEY1     = 16'h5A5A,
  parameter int          TIMEOUT  = 8,
  parameter int          MAX_FAIL = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        bus_wr,
  input  logic [1:0]  bus_addr,
  input  logic [15:0] bus_wdata,
  input  logic        dbg_req,
  input  logic        dbg_auth,
  output logic        write,
  output logic [15:0] data_in,
  output logic        not_lock_status,
  output logic        lock_override,
  output logic        lockout,
  output logic [1:0]  fail_cnt
);
  typedef enum logic [1:0] {UNLOCKED, LOCKED, KEY1_WAIT, LOCKOUT} state_t;
  state_t      state_q, state_d, ok_state;
  logic [7:0]  timer_q, timer_d;
  logic [1:0]  fail_q, fail_d, fail_nx;
  logic        write_q, write_d, ovr_q, ovr_d;
  logic [15:0] data_q, data_d;
  logic        wr_data, wr_lock, wr_key, fail_inc;
  always_comb begin
    wr_data  = bus_wr && bus_addr == 2'd0;
    wr_lock  = bus_wr && bus_addr == 2'd1 && bus_wdata[0];
    wr_key   = bus_wr && bus_addr == 2'd2;
    fail_inc = 1'b0;
    ok_state = state_q;
    timer_d  = 8'd0;
    case (state_q)
      UNLOCKED: ok_state = wr_lock ? LOCKED : UNLOCKED;
      LOCKED: begin
        ok_state = (wr_key && bus_wdata == KEY0) ? KEY1_WAIT : LOCKED;
        fail_inc = wr_key && bus_wdata != KEY0;
        timer_d  = (ok_state == KEY1_WAIT) ? 8'(TIMEOUT) : 8'd0;
      end
      KEY1_WAIT: begin
        // lock abort beats key check, and any key write beats the timeout
        ok_state = wr_lock ? LOCKED :
                   wr_key ? ((bus_wdata == KEY1) ? UNLOCKED : LOCKED) :
                   (timer_q == 8'd1) ? LOCKED : KEY1_WAIT;
        fail_inc = !wr_lock && (wr_key ? bus_wdata != KEY1 : timer_q == 8'd1);
        timer_d  = (ok_state == KEY1_WAIT) ? timer_q - 8'd1 : 8'd0;
      end
      default: ok_state = LOCKOUT;
    endcase
    fail_nx = fail_q + 2'd1;
    state_d = (fail_inc && fail_nx == 2'(MAX_FAIL)) ? LOCKOUT : ok_state;
    fail_d  = fail_inc ? fail_nx :
              (state_q == KEY1_WAIT && ok_state == UNLOCKED) ? 2'd0 : fail_q;
    write_d = wr_data;
    data_d  = wr_data ? bus_wdata : data_q;
    ovr_d   = dbg_req && dbg_auth && state_d != LOCKOUT;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= UNLOCKED;
      timer_q <= 8'd0;
      fail_q  <= 2'd0;
      write_q <= 1'b0;
      data_q  <= 16'h0000;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
      write_q <= write_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end
  assign write           = write_q;
  assign data_in         = data_q;
  assign not_lock_status = state_q == UNLOCKED;
  assign lockout         = state_q == LOCKOUT;
  assign lock_override   = ovr_q;
  assign fail_cnt        = fail_q;
endmodule

// File: tb/tb_reg_lock_ctrl.sv
// tb_reg_lock_ctrl: directed plus random bus traffic checked against a deadline-based lock model.
module tb_reg_lock_ctrl;
  localparam logic [15:0] K0 = 16'hA5A5, K1 = 16'h5A5A;
  localparam int TO = 8, MF = 3;
  logic        clk = 0, resetn = 0, bus_wr = 0, dbg_req = 0, dbg_auth = 0;
  logic [1:0]  bus_addr = 0;
  logic [15:0] bus_wdata = 0;
  logic        write, not_lock_status, lock_override, lockout;
  logic [15:0] data_in;
  logic [1:0]  fail_cnt;
  int n_chk = 0, n_pass = 0;
  bit m_unl = 1, m_wait = 0, m_lo = 0, m_wr = 0, m_ovr = 0;
  int m_fails = 0, cyc = 0, deadline = 0;
  logic [15:0] m_data = 0;
  bit g_rq = 0, g_au = 0;

  reg_lock_ctrl dut (
    .clk(clk), .resetn(resetn), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .dbg_req(dbg_req), .dbg_auth(dbg_auth), .write(write), .data_in(data_in),
    .not_lock_status(not_lock_status), .lock_override(lock_override), .lockout(lockout),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (step %0d)", tag, got, exp, cyc);
  endtask

  task automatic check_all();
    chk("write", 16'(write), 16'(m_wr));
    chk("data_in", data_in, m_data);
    chk("not_lock_status", 16'(not_lock_status), 16'(m_unl));
    chk("lockout", 16'(lockout), 16'(m_lo));
    chk("fail_cnt", 16'(fail_cnt), 16'(m_fails));
    chk("lock_override", 16'(lock_override), 16'(m_ovr));
  endtask

  task automatic m_fail();
    m_fails++;
    m_wait = 0;
    if (m_fails == MF) m_lo = 1;
  endtask

  task automatic step(bit wr, logic [1:0] a, logic [15:0] d);
    @(negedge clk);
    bus_wr = wr; bus_addr = a; bus_wdata = d; dbg_req = g_rq; dbg_auth = g_au;
    cyc++;
    m_wr = wr && a == 2'd0;
    if (m_wr) m_data = d;
    if (m_lo) ;
    else if (m_unl) begin
      if (wr && a == 2'd1 && d[0]) m_unl = 0;
    end else if (m_wait) begin
      if (wr && a == 2'd1 && d[0]) m_wait = 0;
      else if (wr && a == 2'd2) begin
        if (d == K1) begin m_wait = 0; m_unl = 1; m_fails = 0; end
        else m_fail();
      end else if (cyc == deadline) m_fail();
    end else if (wr && a == 2'd2) begin
      if (d == K0) begin m_wait = 1; deadline = cyc + TO; end
      else m_fail();
    end
    m_ovr = g_rq && g_au && !m_lo;
    @(posedge clk);
    #1 check_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 2'd0, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus_wr = 0; g_rq = 0; g_au = 0; dbg_req = 0; dbg_auth = 0;
    #2 resetn = 0;
    m_unl = 1; m_wait = 0; m_lo = 0; m_wr = 0; m_ovr = 0; m_fails = 0; m_data = 0;
    #1 check_all();
    resetn = 1;
  endtask

  initial begin
    #12 resetn = 1;
    do_reset();
    step(1, 2'd0, 16'h1234);
    step(0, 2'd0, 16'h0);
    step(1, 2'd1, 16'h0001);
    step(1, 2'd2, K0);
    idle(2);
    step(1, 2'd2, K1);
    step(1, 2'd1, 16'h0001);
    step(1, 2'd2, K0);
    idle(TO);
    step(1, 2'd2, K1);
    do_reset();
    step(1, 2'd1, 16'h0001);
    for (int i = 0; i < 3; i++) step(1, 2'd2, 16'h0000);
    step(1, 2'd2, K0);
    step(1, 2'd2, K1);
    step(1, 2'd0, 16'hBEEF);
    do_reset();
    step(1, 2'd1, 16'h0001);
    g_rq = 1; g_au = 1;
    idle(1);
    g_au = 0;
    idle(1);
    g_au = 1;
    for (int i = 0; i < 3; i++) step(1, 2'd2, 16'h0001);
    idle(1);
    do_reset();
    step(1, 2'd1, 16'h0001);
    step(1, 2'd2, K0);
    idle(1);
    step(1, 2'd1, 16'h0001);
    step(1, 2'd2, K0);
    idle(TO - 1);
    step(1, 2'd2, K1);
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      if ($urandom_range(0, 80) == 0) do_reset();
      g_rq = $urandom_range(0, 1) == 1;
      g_au = $urandom_range(0, 3) != 0;
      case ($urandom_range(0, 3))
        0: d = K0;
        1: d = K1;
        default: d = 16'($urandom);
      endcase
      if ($urandom_range(0, 9) < 4) step(0, 2'd0, 16'h0);
      else step(1, 2'($urandom_range(0, 3)), d);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
